// File: rtl/adc_frame_gearbox.sv
// rtl/adc_frame_gearbox.sv - multi-lane IN_WIDTH->OUT_WIDTH gearbox with FCO-based word alignment
//
// Purpose:
//   Regroups deserialised lane words (dco_div4 domain) into OUT_WIDTH-bit ADC samples.
//   The FCO lane runs through the same gearbox as the data lanes. While searching, every
//   emitted FCO word that differs from FRAME_PATTERN costs one bit slip on all lanes.
//   After LOCK_COUNT consecutive matches the block reports lock. It drops back to search
//   after MISS_LIMIT consecutive mismatches.
//
// Ports:
//   data_in_clk      in   clock (dco_div4)
//   rstn             in   asynchronous active-low reset
//   data_in          in   NUM_CH lane words, lane k = [k*IN_WIDTH +: IN_WIDTH], MSB = oldest bit
//   fco_in           in   deserialised FCO word, same bit order as data_in
//   data_valid_in    in   qualifies data_in and fco_in
//   align_en         in   1 = search/track alignment, 0 = free-run without slipping
//   data_out         out  NUM_CH samples, lane k = [k*OUT_WIDTH +: OUT_WIDTH]
//   data_valid_out   out  one-cycle strobe per output sample set
//   aligned          out  high while LOCKED
//   slip_count       out  bit slips since reset, modulo OUT_WIDTH
//
// Optional build macro ADC_GEARBOX_STATS_EN adds:
//   frame_err_count  out  saturating count of FCO mismatches seen while LOCKED
//   lock_lost        out  one-cycle pulse on the LOCKED->SEARCH transition

module adc_frame_gearbox #(
  parameter int                   IN_WIDTH      = 8,
  parameter int                   OUT_WIDTH     = 12,
  parameter int                   NUM_CH        = 4,
  parameter logic [OUT_WIDTH-1:0] FRAME_PATTERN = 12'hFC0,
  parameter int                   LOCK_COUNT    = 4,
  parameter int                   MISS_LIMIT    = 2
) (
  input  logic                          data_in_clk,
  input  logic                          rstn,
  input  logic [NUM_CH*IN_WIDTH-1:0]    data_in,
  input  logic [IN_WIDTH-1:0]           fco_in,
  input  logic                          data_valid_in,
  input  logic                          align_en,
  output logic [NUM_CH*OUT_WIDTH-1:0]   data_out,
  output logic                          data_valid_out,
  output logic                          aligned,
  output logic [$clog2(OUT_WIDTH)-1:0]  slip_count
`ifdef ADC_GEARBOX_STATS_EN
  ,
  output logic [15:0]                   frame_err_count,
  output logic                          lock_lost
`endif
);

  localparam int NUM_LANE = NUM_CH + 1;
  localparam int FCO_LANE = NUM_CH;
  localparam int SR_W     = OUT_WIDTH + IN_WIDTH;
  localparam int CNT_W    = $clog2(SR_W + IN_WIDTH);
  localparam int SLIP_W   = $clog2(OUT_WIDTH);
  localparam int MATCH_W  = $clog2(LOCK_COUNT + 1);
  localparam int MISS_W   = $clog2(MISS_LIMIT + 1);

  typedef enum logic [1:0] {S_IDLE, S_SEARCH, S_LOCKED} state_t;

  state_t               state;
  logic [SR_W-1:0]      sr_q [NUM_LANE];
  logic [SR_W-1:0]      sr_d [NUM_LANE];
  logic [IN_WIDTH-1:0]  lane_in [NUM_LANE];
  logic [OUT_WIDTH-1:0] cand [NUM_LANE];
  logic [CNT_W-1:0]     bit_count;
  logic [CNT_W-1:0]     cnt_add;
  logic [CNT_W-1:0]     cnt_sub;
  logic [CNT_W-1:0]     avail;
  logic [CNT_W-1:0]     shift;
  logic [MATCH_W-1:0]   match_cnt;
  logic [MISS_W-1:0]    miss_cnt;
  logic                 slip_pending;
  logic                 emit;
  logic                 fco_match;
  logic                 slip_req;
  logic                 slip_take;
  logic                 slip_defer;
  logic                 word_out;

  for (genvar k = 0; k < NUM_CH; k++) begin : g_lane_in
    assign lane_in[k] = data_in[k*IN_WIDTH +: IN_WIDTH];
  end
  assign lane_in[FCO_LANE] = fco_in;

  // Valid bits sit at the LSB end of each shift register; the oldest bit is at
  // position bit_count-1, so the emitted word is the top OUT_WIDTH valid bits.
  assign emit  = (bit_count >= CNT_W'(OUT_WIDTH));
  assign shift = bit_count - CNT_W'(OUT_WIDTH);

  always_comb begin
    for (int l = 0; l < NUM_LANE; l++) begin
      cand[l] = OUT_WIDTH'(sr_q[l] >> shift);
      // Bits dropped off the top here are always part of the word emitted this cycle.
      sr_d[l] = data_valid_in ? {sr_q[l][SR_W-IN_WIDTH-1:0], lane_in[l]} : sr_q[l];
    end
  end

  assign cnt_add = data_valid_in ? CNT_W'(IN_WIDTH) : '0;
  assign cnt_sub = emit ? CNT_W'(OUT_WIDTH) : '0;
  // Bits left after this cycle's append and emit, before any slip.
  assign avail   = bit_count + cnt_add - cnt_sub;

  assign fco_match = (cand[FCO_LANE] == FRAME_PATTERN);
  assign slip_req  = emit && align_en && (state == S_SEARCH) && !fco_match;
  assign word_out  = emit && !slip_req;

  // A slip needs one bit left behind the emitted word; otherwise it waits for more input.
  assign slip_take  = align_en && (slip_req || slip_pending) && (avail != '0);
  assign slip_defer = align_en && (slip_req || slip_pending) && (avail == '0);

  always_ff @(posedge data_in_clk or negedge rstn) begin
    if (!rstn) begin
      state          <= S_IDLE;
      bit_count      <= '0;
      slip_pending   <= 1'b0;
      slip_count     <= '0;
      match_cnt      <= '0;
      miss_cnt       <= '0;
      data_out       <= '0;
      data_valid_out <= 1'b0;
      aligned        <= 1'b0;
      for (int l = 0; l < NUM_LANE; l++) sr_q[l] <= '0;
`ifdef ADC_GEARBOX_STATS_EN
      frame_err_count <= '0;
      lock_lost       <= 1'b0;
`endif
    end else begin
      for (int l = 0; l < NUM_LANE; l++) sr_q[l] <= sr_d[l];
      bit_count      <= avail - (slip_take ? CNT_W'(1) : CNT_W'(0));
      slip_pending   <= slip_defer;
      data_valid_out <= word_out;
      if (slip_take)
        slip_count <= (slip_count == SLIP_W'(OUT_WIDTH - 1)) ? '0 : slip_count + 1'b1;
      if (word_out)
        for (int k = 0; k < NUM_CH; k++) data_out[k*OUT_WIDTH +: OUT_WIDTH] <= cand[k];
`ifdef ADC_GEARBOX_STATS_EN
      lock_lost <= 1'b0;
`endif

      if (!align_en) begin
        state     <= S_IDLE;
        aligned   <= 1'b0;
        match_cnt <= '0;
        miss_cnt  <= '0;
      end else begin
        case (state)
          S_IDLE: begin
            state     <= S_SEARCH;
            aligned   <= 1'b0;
            match_cnt <= '0;
            miss_cnt  <= '0;
          end
          S_SEARCH: begin
            if (emit) begin
              if (!fco_match) begin
                match_cnt <= '0;
              end else if ((int'(match_cnt) + 1) == LOCK_COUNT) begin
                state     <= S_LOCKED;
                aligned   <= 1'b1;
                match_cnt <= '0;
                miss_cnt  <= '0;
              end else begin
                match_cnt <= match_cnt + 1'b1;
              end
            end
          end
          S_LOCKED: begin
            if (emit) begin
              if (fco_match) begin
                miss_cnt <= '0;
              end else begin
`ifdef ADC_GEARBOX_STATS_EN
                if (frame_err_count != 16'hFFFF) frame_err_count <= frame_err_count + 1'b1;
`endif
                if ((int'(miss_cnt) + 1) == MISS_LIMIT) begin
                  // Relock search restarts in place; no slip is taken for these misses.
                  state     <= S_SEARCH;
                  aligned   <= 1'b0;
                  miss_cnt  <= '0;
                  match_cnt <= '0;
`ifdef ADC_GEARBOX_STATS_EN
                  lock_lost <= 1'b1;
`endif
                end else begin
                  miss_cnt <= miss_cnt + 1'b1;
                end
              end
            end
          end
          default: begin
            state   <= S_IDLE;
            aligned <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_adc_frame_gearbox.sv
// tb/tb_adc_frame_gearbox.sv - directed self-checking bench for adc_frame_gearbox

module tb_adc_frame_gearbox;

  localparam int IW = 8;
  localparam int OW = 12;
  localparam int NC = 4;

  logic             data_in_clk = 1'b0;
  logic             rstn;
  logic [NC*IW-1:0] data_in;
  logic [IW-1:0]    fco_in;
  logic             data_valid_in;
  logic             align_en;
  logic [NC*OW-1:0] data_out;
  logic             data_valid_out;
  logic             aligned;
  logic [3:0]       slip_count;
`ifdef ADC_GEARBOX_STATS_EN
  logic [15:0]      frame_err_count;
  logic             lock_lost;
  int               lost_cnt;
`endif

  int          tests = 0;
  int          fails = 0;
  int          wptr  = 0;
  int          off   = 0;
  logic [63:0] fco_bad = '0;
  logic [NC*OW-1:0] q_data[$];
  logic             q_al[$];

  always #5 data_in_clk = ~data_in_clk;

  adc_frame_gearbox dut (
    .data_in_clk    (data_in_clk),
    .rstn           (rstn),
    .data_in        (data_in),
    .fco_in         (fco_in),
    .data_valid_in  (data_valid_in),
    .align_en       (align_en),
    .data_out       (data_out),
    .data_valid_out (data_valid_out),
    .aligned        (aligned),
    .slip_count     (slip_count)
`ifdef ADC_GEARBOX_STATS_EN
    ,
    .frame_err_count(frame_err_count),
    .lock_lost      (lock_lost)
`endif
  );

  always @(negedge data_in_clk) begin
    if (rstn === 1'b1 && data_valid_out === 1'b1) begin
      q_data.push_back(data_out);
      q_al.push_back(aligned);
    end
`ifdef ADC_GEARBOX_STATS_EN
    if (rstn === 1'b1 && lock_lost === 1'b1) lost_cnt++;
`endif
  end

  function automatic logic [11:0] ramp(int k, int n);
    return 12'(256 * k + n);
  endfunction

  function automatic logic [NC*OW-1:0] exp_word(int n);
    return {ramp(3, n), ramp(2, n), ramp(1, n), ramp(0, n)};
  endfunction

  // Bit p of lane's raw stream; lane NC is the FCO lane. The stream starts 'off'
  // bits before the first aligned sample boundary.
  function automatic logic sbit(int lane, int p);
    int a, r;
    logic [11:0] fp;
    logic [11:0] v;
    fp = 12'hFC0;
    a  = p - off;
    r  = ((a % 12) + 12) % 12;
    if (lane == NC) begin
      if (a < 0) return fp[11-r];
      return fp[11-r] ^ fco_bad[a/12];
    end
    if (a < 0) return 1'b0;
    v = ramp(lane, a / 12);
    return v[11-r];
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge data_in_clk);
    #1;
  endtask

  task automatic put_word();
    for (int j = 0; j < IW; j++) begin
      for (int k = 0; k < NC; k++) data_in[k*IW + (IW-1-j)] = sbit(k, IW*wptr + j);
      fco_in[IW-1-j] = sbit(NC, IW*wptr + j);
    end
    data_valid_in = 1'b1;
    wptr++;
  endtask

  task automatic feed(input int n, input bit gap);
    for (int i = 0; i < n; i++) begin
      put_word();
      tick();
      if (gap) begin
        data_valid_in = 1'b0;
        tick();
        tick();
      end
    end
    data_valid_in = 1'b0;
    repeat (4) tick();
  endtask

  task automatic do_reset(input logic en, input int offset, input logic [63:0] bad);
    rstn          = 1'b0;
    data_valid_in = 1'b0;
    data_in       = '0;
    fco_in        = '0;
    align_en      = en;
    off           = offset;
    fco_bad       = bad;
    wptr          = 0;
    tick();
    tick();
    q_data.delete();
    q_al.delete();
`ifdef ADC_GEARBOX_STATS_EN
    lost_cnt = 0;
`endif
    rstn = 1'b1;
  endtask

  task automatic check_stream(input string tag, input int first, input int n);
    chk({tag, "_count"}, 64'(q_data.size()), 64'(n));
    for (int i = 0; i < q_data.size() && i < n; i++)
      chk($sformatf("%s_sample%0d", tag, first + i), 64'(q_data[i]), 64'(exp_word(first + i)));
  endtask

  initial begin
    logic [NC*OW-1:0] w;

    // Reset state
    do_reset(1'b1, 0, '0);
    chk("rst_data_out", 64'(data_out), 64'h0);
    chk("rst_valid", 64'(data_valid_out), 64'h0);
    chk("rst_aligned", 64'(aligned), 64'h0);
    chk("rst_slip", 64'(slip_count), 64'h0);

    // 1: already aligned stream, 30 words -> 20 samples
    feed(30, 1'b0);
    chk("t1_slip", 64'(slip_count), 64'h0);
    chk("t1_aligned", 64'(aligned), 64'h1);
    chk("t1_al_word3", 64'(q_al[2]), 64'h0);
    chk("t1_al_word4", 64'(q_al[3]), 64'h1);
    check_stream("t1", 0, 20);

    // 2: misaligned by 5 bits -> 5 slips, first output is sample 5
    do_reset(1'b1, 5, '0);
    feed(30, 1'b0);
    chk("t2_slip", 64'(slip_count), 64'h5);
    chk("t2_aligned", 64'(aligned), 64'h1);
    w = q_data[0];
    chk("t2_first_lane2", 64'(w[35:24]), 64'h205);
    chk("t2_al_word3", 64'(q_al[2]), 64'h0);
    chk("t2_al_word4", 64'(q_al[3]), 64'h1);
    check_stream("t2", 5, 14);

    // 3: same misaligned stream, valid gapped 1-in-3
    do_reset(1'b1, 5, '0);
    feed(30, 1'b1);
    chk("t3_slip", 64'(slip_count), 64'h5);
    chk("t3_aligned", 64'(aligned), 64'h1);
    check_stream("t3", 5, 14);

    // 4: single FCO miss keeps lock; two consecutive drop it; relock in place
    do_reset(1'b1, 0, 64'h1 << 8);
    feed(18, 1'b0);
    chk("t4_single_miss_aligned", 64'(aligned), 64'h1);
    fco_bad = (64'h1 << 8) | (64'h1 << 14) | (64'h1 << 15);
    feed(12, 1'b0);
    chk("t4_slip", 64'(slip_count), 64'h0);
    chk("t4_aligned_end", 64'(aligned), 64'h1);
    chk("t4_al_word9", 64'(q_al[8]), 64'h1);
    chk("t4_al_word16", 64'(q_al[15]), 64'h0);
    chk("t4_al_word17", 64'(q_al[16]), 64'h0);
    chk("t4_al_word20", 64'(q_al[19]), 64'h1);
    check_stream("t4", 0, 20);

    // 5: reset asserted with bit_count=4 while data_out holds sample 0
    do_reset(1'b1, 0, '0);
    put_word();
    tick();
    put_word();
    tick();
    data_valid_in = 1'b0;
    tick();
    chk("t5_pre_valid", 64'(data_valid_out), 64'h1);
    chk("t5_pre_data", 64'(data_out), 64'(exp_word(0)));
    @(negedge data_in_clk);
    rstn = 1'b0;
    #1;
    chk("t5_rst_data_out", 64'(data_out), 64'h0);
    chk("t5_rst_valid", 64'(data_valid_out), 64'h0);
    chk("t5_rst_aligned", 64'(aligned), 64'h0);
    tick();
    do_reset(1'b1, 0, '0);
    feed(12, 1'b0);
    chk("t5_aligned", 64'(aligned), 64'h1);
    check_stream("t5", 0, 8);

    // Free-run: align_en=0 never slips or locks
    do_reset(1'b0, 5, '0);
    feed(30, 1'b0);
    chk("fr_slip", 64'(slip_count), 64'h0);
    chk("fr_aligned", 64'(aligned), 64'h0);
    chk("fr_count", 64'(q_data.size()), 64'd20);

`ifdef ADC_GEARBOX_STATS_EN
    // 6: three isolated misses, then MISS_LIMIT consecutive misses
    do_reset(1'b1, 0, (64'h1 << 6) | (64'h1 << 8) | (64'h1 << 10));
    feed(18, 1'b0);
    chk("t6_err3", 64'(frame_err_count), 64'd3);
    chk("t6_no_lost", 64'(lost_cnt), 64'd0);
    chk("t6_aligned", 64'(aligned), 64'h1);
    fco_bad = fco_bad | (64'h1 << 12) | (64'h1 << 13);
    feed(12, 1'b0);
    chk("t6_err5", 64'(frame_err_count), 64'd5);
    chk("t6_one_lost", 64'(lost_cnt), 64'd1);
    chk("t6_relocked", 64'(aligned), 64'h1);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
